// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller at a fixed 8x oversampling ratio: detects the start
// edge, runs the frame FSM, drives the sampler/deserializer counters and checks parity/stop.
module uart_rx_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic       sampled_bit,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  output logic [2:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       dat_samp_en,
  output logic       deser_en,
  output logic       data_valid,
  output logic       par_err,
  output logic       stp_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic [2:0] LAST_EDGE = 3'd7;
  localparam logic [3:0] LAST_DATA = 4'd8;

  state_e     state_q, state_d;
  logic [2:0] edge_cnt_q, edge_cnt_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       par_en_q, par_en_d;
  logic       par_typ_q, par_typ_d;
  logic       par_acc_q, par_acc_d;
  logic       par_err_q, par_err_d;
  logic       stp_err_q, stp_err_d;
  logic       dat_samp_en_q, dat_samp_en_d;
  logic       deser_en_q, deser_en_d;
  logic       data_valid_q, data_valid_d;

  logic bit_end;
  logic start_det;

  // Every per-bit decision is taken in the last oversample slot of that bit.
  assign bit_end   = (edge_cnt_q == LAST_EDGE);
  assign start_det = (state_q == IDLE) && !RX_IN;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always written with <= so every flop samples the
  // pre-edge values of its neighbours regardless of process ordering.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: a default assignment at the top of each always_comb guarantees every
  // path drives every output, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!RX_IN) state_d = START;
      end
      START: begin
        if (bit_end) state_d = sampled_bit ? IDLE : DATA;
      end
      DATA: begin
        if (bit_end && (bit_cnt_q == LAST_DATA)) begin
          state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    edge_cnt_d    = edge_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    par_en_d      = par_en_q;
    par_typ_d     = par_typ_q;
    par_acc_d     = par_acc_q;
    par_err_d     = par_err_q;
    stp_err_d     = stp_err_q;
    data_valid_d  = 1'b0;
    dat_samp_en_d = (state_d != IDLE);
    deser_en_d    = (state_d == DATA);

    // The detection cycle is edge 0 of the start bit, so the first START cycle is edge 1.
    if (state_d == IDLE) begin
      edge_cnt_d = 3'd0;
      bit_cnt_d  = 4'd0;
    end else if (state_q == IDLE) begin
      edge_cnt_d = 3'd1;
      bit_cnt_d  = 4'd0;
    end else begin
      edge_cnt_d = edge_cnt_q + 3'd1;
      bit_cnt_d  = bit_cnt_q + {3'b000, bit_end};
    end

    if (start_det) begin
      par_en_d  = PAR_EN;
      par_typ_d = PAR_TYP;
      par_acc_d = 1'b0;
      par_err_d = 1'b0;
      stp_err_d = 1'b0;
    end

    if (bit_end) begin
      unique case (state_q)
        DATA: begin
          par_acc_d = par_acc_q ^ sampled_bit;
        end
        PARITY: begin
          // Even parity expects the data XOR, odd parity its complement.
          par_err_d = par_err_q | (sampled_bit != (par_acc_q ^ par_typ_q));
        end
        STOP: begin
          stp_err_d    = stp_err_q | ~sampled_bit;
          data_valid_d = sampled_bit & ~par_err_q;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  // NOTE: every flop here has an asynchronous reset; there is no storage array,
  // so nothing is deliberately left unreset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt_q    <= 3'd0;
      bit_cnt_q     <= 4'd0;
      par_en_q      <= 1'b0;
      par_typ_q     <= 1'b0;
      par_acc_q     <= 1'b0;
      par_err_q     <= 1'b0;
      stp_err_q     <= 1'b0;
      dat_samp_en_q <= 1'b0;
      deser_en_q    <= 1'b0;
      data_valid_q  <= 1'b0;
    end else begin
      edge_cnt_q    <= edge_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      par_en_q      <= par_en_d;
      par_typ_q     <= par_typ_d;
      par_acc_q     <= par_acc_d;
      par_err_q     <= par_err_d;
      stp_err_q     <= stp_err_d;
      dat_samp_en_q <= dat_samp_en_d;
      deser_en_q    <= deser_en_d;
      data_valid_q  <= data_valid_d;
    end
  end

  assign edge_cnt    = edge_cnt_q;
  assign bit_cnt     = bit_cnt_q;
  assign dat_samp_en = dat_samp_en_q;
  assign deser_en    = deser_en_q;
  assign data_valid  = data_valid_q;
  assign par_err     = par_err_q;
  assign stp_err     = stp_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: table-driven frames, hand-written corner
// sequences and randomized frames checked against a frame-position model.
module tb_uart_rx_ctrl;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic       sampled_bit;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [2:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en;
  logic       deser_en;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int shift_cnt = 0;
  logic [7:0] deser_q = 8'h00;
  int pulses[$];

  typedef struct {
    logic [7:0] data;
    bit         par_en;
    bit         par_typ;
    bit         par_bit;
    bit         stop_bit;
    bit         exp_valid;
    bit         exp_pe;
    bit         exp_se;
    int         exp_len;
  } vec_t;

  uart_rx_ctrl dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .sampled_bit (sampled_bit),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .dat_samp_en (dat_samp_en),
    .deser_en    (deser_en),
    .data_valid  (data_valid),
    .par_err     (par_err),
    .stp_err     (stp_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Deserializer consumer: shifts LSB-first on the last oversample of each data bit.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (deser_en && edge_cnt == 3'd7) begin
      deser_q   <= {sampled_bit, deser_q[7:1]};
      shift_cnt <= shift_cnt + 1;
    end
  end

  always @(negedge CLK) begin
    if (data_valid === 1'b1) pulses.push_back(cyc);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] outs();
    return {edge_cnt, bit_cnt, dat_samp_en, deser_en, data_valid, par_err, stp_err};
  endfunction

  // Expected outputs k cycles after the detection cycle of a frame of length len.
  function automatic logic [11:0] model_outs(int k, int len, bit par_en,
                                             bit exp_valid, bit exp_pe, bit exp_se);
    logic [2:0] e;
    logic [3:0] b;
    bit         de;
    bit         pe;
    if (k == len) return {3'd0, 4'd0, 1'b0, 1'b0, exp_valid, exp_pe, exp_se};
    e  = 3'(k % 8);
    b  = 4'(k / 8);
    de = (k / 8 >= 1) && (k / 8 <= 8);
    pe = (par_en && k / 8 >= 10) ? exp_pe : 1'b0;
    return {e, b, 1'b1, de, 1'b0, pe, 1'b0};
  endfunction

  function automatic bit line_bit(int b, logic [7:0] data, bit par_en, bit par_bit, bit stop_bit);
    if (b == 0) return 1'b0;
    if (b <= 8) return data[b-1];
    if (b == 9 && par_en) return par_bit;
    return stop_bit;
  endfunction

  task automatic idle(input int n);
    RX_IN       = 1'b1;
    sampled_bit = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  // Entered at a negedge with the DUT idle; returns at the negedge of the data_valid cycle.
  task automatic run_frame(input logic [7:0] data, input bit par_en, input bit par_typ,
                           input bit par_bit, input bit stop_bit, input bit exp_valid,
                           input bit exp_pe, input bit exp_se, input int len, input string tag);
    int shifts0;
    int de_cnt;
    de_cnt  = 0;
    check($sformatf("%s idle counters", tag), 32'({edge_cnt, bit_cnt, dat_samp_en, deser_en}), 32'd0);
    shifts0     = shift_cnt;
    PAR_EN      = par_en;
    PAR_TYP     = par_typ;
    RX_IN       = 1'b0;
    sampled_bit = 1'b0;
    for (int k = 1; k <= len; k++) begin
      @(negedge CLK);
      check($sformatf("%s k=%0d outputs", tag, k), 32'(outs()),
            32'(model_outs(k, len, par_en, exp_valid, exp_pe, exp_se)));
      if (deser_en) de_cnt++;
      if (k < len) begin
        RX_IN       = line_bit(k / 8, data, par_en, par_bit, stop_bit);
        sampled_bit = RX_IN;
        PAR_EN      = 1'($urandom_range(0, 1));
        PAR_TYP     = 1'($urandom_range(0, 1));
      end else begin
        RX_IN       = 1'b1;
        sampled_bit = 1'b1;
      end
    end
    check($sformatf("%s deser_en cycles", tag), 32'(de_cnt), 32'd64);
    check($sformatf("%s shift count", tag), 32'(shift_cnt - shifts0), 32'd8);
    check($sformatf("%s deser byte", tag), 32'(deser_q), 32'(data));
  endtask

  initial begin
    vec_t       vecs[8];
    logic [7:0] rdata;
    bit         rpe, rpt, rpb, rsb, epe, ese, ev;
    int         n0;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 80};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 88};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 88};
    vecs[3] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 88};
    vecs[4] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 80};
    vecs[5] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 88};
    vecs[6] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 88};
    vecs[7] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 88};

    RST         = 1'b0;
    RX_IN       = 1'b1;
    sampled_bit = 1'b1;
    PAR_EN      = 1'b0;
    PAR_TYP     = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset outputs", 32'(outs()), 32'd0);
    RST = 1'b1;
    idle(2);
    check("idle after reset", 32'(outs()), 32'd0);

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i].data, vecs[i].par_en, vecs[i].par_typ, vecs[i].par_bit,
                vecs[i].stop_bit, vecs[i].exp_valid, vecs[i].exp_pe, vecs[i].exp_se,
                vecs[i].exp_len, $sformatf("vec%0d", i));
      idle(3);
      check($sformatf("vec%0d flags hold", i), 32'({par_err, stp_err}),
            32'({vecs[i].exp_pe, vecs[i].exp_se}));
    end

    // False start: line low for 3 cycles only
    RX_IN       = 1'b0;
    sampled_bit = 1'b0;
    PAR_EN      = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      check($sformatf("false start k=%0d", k), 32'(outs()),
            (k < 8) ? 32'({3'(k), 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) : 32'd0);
      RX_IN       = (k >= 3);
      sampled_bit = RX_IN;
    end
    idle(2);
    run_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 80, "after false start");
    idle(2);

    // Back-to-back frames: second start bit begins in the data_valid cycle
    n0 = pulses.size();
    run_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 80, "b2b first");
    run_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 80, "b2b second");
    idle(2);
    check("b2b pulse count", 32'(pulses.size() - n0), 32'd2);
    if (pulses.size() >= n0 + 2) begin
      check("b2b pulse spacing", 32'(pulses[n0+1] - pulses[n0]), 32'd80);
    end

    // Randomized frames against the rule-based model
    for (int i = 0; i < 30; i++) begin
      rdata = 8'($urandom);
      rpe   = 1'($urandom_range(0, 1));
      rpt   = 1'($urandom_range(0, 1));
      rpb   = ($urandom_range(0, 3) != 0) ? (^rdata ^ rpt) : ~(^rdata ^ rpt);
      rsb   = ($urandom_range(0, 3) != 0);
      epe   = rpe && (rpb != ((^rdata) ^ rpt));
      ese   = !rsb;
      ev    = rsb && !epe;
      run_frame(rdata, rpe, rpt, rpb, rsb, ev, epe, ese, rpe ? 88 : 80,
                $sformatf("rand%0d", i));
      if ($urandom_range(0, 1) != 0) idle($urandom_range(1, 4));
    end
    idle(2);

    // Reset asserted mid-frame at bit_cnt 4
    RX_IN       = 1'b0;
    sampled_bit = 1'b0;
    PAR_EN      = 1'b1;
    PAR_TYP     = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      @(negedge CLK);
      RX_IN       = line_bit(k / 8, 8'hA5, 1'b1, 1'b0, 1'b1);
      sampled_bit = RX_IN;
    end
    check("bit_cnt before reset", 32'(bit_cnt), 32'd4);
    #2 RST = 1'b0;
    #1 check("outputs during reset", 32'(outs()), 32'd0);
    @(negedge CLK);
    RX_IN       = 1'b1;
    sampled_bit = 1'b1;
    RST         = 1'b1;
    n0          = pulses.size();
    repeat (100) @(negedge CLK);
    check("no pulse after abort", 32'(pulses.size() - n0), 32'd0);
    check("idle after abort", 32'(outs()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
